// File: rtl/lsq_queue.sv
// In-order load/store queue between dispatch, the ROB/CDB and the memory port.
// Optional macro LSQ_MISALIGN_EN: misaligned accesses raise res_exc instead of reaching memory.
module lsq_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FULL_MARGIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             disp_valid,
    input  logic             disp_is_store,
    input  logic [2:0]       disp_funct3,
    input  logic [TAG_W-1:0] disp_tag,
    input  logic [11:0]      disp_imm,
    input  logic [TAG_W-1:0] disp_q1,
    input  logic [TAG_W-1:0] disp_q2,
    input  logic [XLEN-1:0]  disp_v1,
    input  logic [XLEN-1:0]  disp_v2,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             st_ready_valid,
    output logic [TAG_W-1:0] st_ready_tag,
    input  logic             rob_commit_valid,
    input  logic [TAG_W-1:0] rob_commit_tag,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [1:0]       mem_size,
    input  logic             mem_done,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [XLEN-1:0]  res_data,
    output logic             res_exc
);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned PTR_W   = IDX_W + 1;
    localparam int unsigned FULL_AT = DEPTH - FULL_MARGIN;

    typedef enum logic [1:0] {IDLE, ST_WAIT, MEM, DRAIN} state_e;

    typedef struct packed {
        logic             valid;
        logic             is_store;
        logic [2:0]       funct3;
        logic [TAG_W-1:0] tag;
        logic [11:0]      imm;
        logic [TAG_W-1:0] q1;
        logic [TAG_W-1:0] q2;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           new_ent;
    entry_t           head_ent;
    state_e           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count_d;
    logic             full_q, full_d;
    logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [1:0]       mem_size_q, mem_size_d;
    logic             st_ready_valid_q, st_ready_valid_d;
    logic [TAG_W-1:0] st_ready_tag_q, st_ready_tag_d;
    logic             res_valid_q, res_valid_d, res_exc_q, res_exc_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [XLEN-1:0]  res_data_q, res_data_d;

    logic [IDX_W-1:0] head_idx, tail_idx;
    logic             head_rdy, head_mis, commit_hit, pop, enq;
    logic [XLEN-1:0]  head_addr, head_wdata, load_ext;

    assign head_idx   = head_q[IDX_W-1:0];
    assign tail_idx   = tail_q[IDX_W-1:0];
    assign head_ent   = ent_q[head_idx];
    assign head_rdy   = head_ent.valid && (head_ent.q1 == '0) &&
                        (!head_ent.is_store || (head_ent.q2 == '0));
    assign head_addr  = head_ent.v1 + {{(XLEN-12){head_ent.imm[11]}}, head_ent.imm};
    assign commit_hit = rob_commit_valid && (rob_commit_tag == head_ent.tag);
    assign enq        = disp_valid && !full_q && !flush;

`ifdef LSQ_MISALIGN_EN
    assign head_mis = ((head_ent.funct3[1:0] == 2'b01) && head_addr[0]) ||
                      ((head_ent.funct3[1:0] == 2'b10) && (head_addr[1:0] != 2'b00));
`else
    assign head_mis = 1'b0;
`endif

    // Store data trimmed to access size; load data extended per funct3[2].
    always_comb begin
        head_wdata = head_ent.v2;
        load_ext   = mem_rdata;
        case (head_ent.funct3[1:0])
            2'b00: begin
                head_wdata = XLEN'(head_ent.v2[7:0]);
                load_ext   = head_ent.funct3[2] ? XLEN'(mem_rdata[7:0]) :
                             {{(XLEN-8){mem_rdata[7]}}, mem_rdata[7:0]};
            end
            2'b01: begin
                head_wdata = XLEN'(head_ent.v2[15:0]);
                load_ext   = head_ent.funct3[2] ? XLEN'(mem_rdata[15:0]) :
                             {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
            end
            default: ;
        endcase
    end

    // Head-of-queue sequencing and pointer update.
    always_comb begin
        state_d          = state_q;
        head_d           = head_q;
        tail_d           = tail_q;
        pop              = 1'b0;
        mem_req_d        = mem_req_q;
        mem_we_d         = mem_we_q;
        mem_addr_d       = mem_addr_q;
        mem_wdata_d      = mem_wdata_q;
        mem_size_d       = mem_size_q;
        st_ready_valid_d = 1'b0;
        st_ready_tag_d   = st_ready_tag_q;
        res_valid_d      = 1'b0;
        res_tag_d        = res_tag_q;
        res_data_d       = res_data_q;
        res_exc_d        = res_exc_q;

        case (state_q)
            IDLE: begin
                if (!flush && head_rdy) begin
                    if (head_ent.is_store) begin
                        st_ready_valid_d = 1'b1;
                        st_ready_tag_d   = head_ent.tag;
                        state_d          = ST_WAIT;
                    end else if (head_mis) begin
                        res_valid_d = 1'b1;
                        res_tag_d   = head_ent.tag;
                        res_data_d  = head_addr;
                        res_exc_d   = 1'b1;
                        pop         = 1'b1;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = head_addr;
                        mem_size_d = head_ent.funct3[1:0];
                        state_d    = MEM;
                    end
                end
            end
            ST_WAIT: begin
                if (!flush && commit_hit) begin
                    if (head_mis) begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = head_addr;
                        mem_wdata_d = head_wdata;
                        mem_size_d  = head_ent.funct3[1:0];
                        state_d     = MEM;
                    end
                end
            end
            MEM: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                    if (!flush) begin
                        pop = 1'b1;
                        if (!mem_we_q) begin
                            res_valid_d = 1'b1;
                            res_tag_d   = head_ent.tag;
                            res_data_d  = load_ext;
                            res_exc_d   = 1'b0;
                        end
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An access already on the bus keeps its head slot until it drains.
        if (flush) begin
            if (state_q == IDLE || state_q == ST_WAIT) begin
                head_d  = '0;
                tail_d  = '0;
                state_d = IDLE;
            end else begin
                tail_d = head_q;
            end
        end else begin
            if (pop) head_d = head_q + PTR_W'(1);
            if (enq) tail_d = tail_q + PTR_W'(1);
        end
        count_d = tail_d - head_d;
        full_d  = (32'(count_d) >= FULL_AT);
    end

    // New entry, woken in the same cycle if the CDB carries its producer.
    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.is_store = disp_is_store;
        new_ent.funct3   = disp_funct3;
        new_ent.tag      = disp_tag;
        new_ent.imm      = disp_imm;
        new_ent.q1       = disp_q1;
        new_ent.q2       = disp_q2;
        new_ent.v1       = disp_v1;
        new_ent.v2       = disp_v2;
        if (cdb_valid && (disp_q1 != '0) && (disp_q1 == cdb_tag)) begin
            new_ent.q1 = '0;
            new_ent.v1 = cdb_data;
        end
        if (cdb_valid && (disp_q2 != '0) && (disp_q2 == cdb_tag)) begin
            new_ent.q2 = '0;
            new_ent.v2 = cdb_data;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (flush) begin
                ent_d[i].valid = 1'b0;
            end else if (ent_q[i].valid && cdb_valid) begin
                if ((ent_q[i].q1 != '0) && (ent_q[i].q1 == cdb_tag)) begin
                    ent_d[i].q1 = '0;
                    ent_d[i].v1 = cdb_data;
                end
                if ((ent_q[i].q2 != '0) && (ent_q[i].q2 == cdb_tag)) begin
                    ent_d[i].q2 = '0;
                    ent_d[i].v2 = cdb_data;
                end
            end
        end
        if (pop) ent_d[head_idx].valid = 1'b0;
        if (enq) ent_d[tail_idx] = new_ent;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            state_q          <= IDLE;
            head_q           <= '0;
            tail_q           <= '0;
            full_q           <= 1'b0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_wdata_q      <= '0;
            mem_size_q       <= '0;
            st_ready_valid_q <= 1'b0;
            st_ready_tag_q   <= '0;
            res_valid_q      <= 1'b0;
            res_tag_q        <= '0;
            res_data_q       <= '0;
            res_exc_q        <= 1'b0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            state_q          <= state_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            full_q           <= full_d;
            mem_req_q        <= mem_req_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_size_q       <= mem_size_d;
            st_ready_valid_q <= st_ready_valid_d;
            st_ready_tag_q   <= st_ready_tag_d;
            res_valid_q      <= res_valid_d;
            res_tag_q        <= res_tag_d;
            res_data_q       <= res_data_d;
            res_exc_q        <= res_exc_d;
        end
    end

    assign full           = full_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_size       = mem_size_q;
    assign st_ready_valid = st_ready_valid_q;
    assign st_ready_tag   = st_ready_tag_q;
    assign res_valid      = res_valid_q;
    assign res_tag        = res_tag_q;
    assign res_data       = res_data_q;
    assign res_exc        = res_exc_q;

endmodule

// File: tb/tb_lsq_queue.sv
// Scoreboard bench for lsq_queue: stimulus queues expected memory requests,
// load results and store-ready pulses; a negedge monitor pops and compares them.
module tb_lsq_queue;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst, rdy, flush;
    logic             disp_valid, disp_is_store;
    logic [2:0]       disp_funct3;
    logic [TAG_W-1:0] disp_tag, disp_q1, disp_q2;
    logic [11:0]      disp_imm;
    logic [XLEN-1:0]  disp_v1, disp_v2;
    logic             full;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             st_ready_valid;
    logic [TAG_W-1:0] st_ready_tag;
    logic             rob_commit_valid;
    logic [TAG_W-1:0] rob_commit_tag;
    logic             mem_req, mem_we, mem_done;
    logic [XLEN-1:0]  mem_addr, mem_wdata, mem_rdata;
    logic [1:0]       mem_size;
    logic             res_valid, res_exc;
    logic [TAG_W-1:0] res_tag;
    logic [XLEN-1:0]  res_data;

    lsq_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .FULL_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .disp_valid(disp_valid), .disp_is_store(disp_is_store), .disp_funct3(disp_funct3),
        .disp_tag(disp_tag), .disp_imm(disp_imm), .disp_q1(disp_q1), .disp_q2(disp_q2),
        .disp_v1(disp_v1), .disp_v2(disp_v2), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .st_ready_valid(st_ready_valid), .st_ready_tag(st_ready_tag),
        .rob_commit_valid(rob_commit_valid), .rob_commit_tag(rob_commit_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_exc(res_exc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } mem_exp_t;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
        logic        exc;
    } res_exp_t;

    mem_exp_t   mem_exp_q[$];
    res_exp_t   res_exp_q[$];
    logic [4:0] st_exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       mem_req_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each new request, result pulse or store-ready pulse consumes one expectation.
    always @(negedge clk) begin : monitor
        mem_exp_t me;
        res_exp_t re;
        logic [4:0] se;
        if (rst) begin
            mem_req_prev = 1'b0;
        end else begin
            if (mem_req && !mem_req_prev) begin
                if (mem_exp_q.size() == 0) begin
                    check("mem_req_unexpected", 32'(mem_req), 32'd0);
                end else begin
                    me = mem_exp_q.pop_front();
                    check("mem_we", 32'(mem_we), 32'(me.we));
                    check("mem_addr", mem_addr, me.addr);
                    check("mem_size", 32'(mem_size), 32'(me.size));
                    if (me.we) check("mem_wdata", mem_wdata, me.wdata);
                end
            end
            mem_req_prev = mem_req;
            if (res_valid) begin
                if (res_exp_q.size() == 0) begin
                    check("res_valid_unexpected", 32'(res_valid), 32'd0);
                end else begin
                    re = res_exp_q.pop_front();
                    check("res_tag", 32'(res_tag), 32'(re.tag));
                    check("res_data", res_data, re.data);
                    check("res_exc", 32'(res_exc), 32'(re.exc));
                end
            end
            if (st_ready_valid) begin
                if (st_exp_q.size() == 0) begin
                    check("st_ready_unexpected", 32'(st_ready_valid), 32'd0);
                end else begin
                    se = st_exp_q.pop_front();
                    check("st_ready_tag", 32'(st_ready_tag), 32'(se));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] size);
        mem_exp_q.push_back('{we, addr, wd, size});
    endtask

    task automatic exp_res(input logic [4:0] tag, input logic [31:0] data, input logic exc);
        res_exp_q.push_back('{tag, data, exc});
    endtask

    task automatic dispatch(input logic st, input logic [2:0] f3, input logic [4:0] tag,
                            input logic [11:0] imm, input logic [4:0] q1, input logic [31:0] v1,
                            input logic [4:0] q2, input logic [31:0] v2);
        disp_valid = 1'b1; disp_is_store = st; disp_funct3 = f3; disp_tag = tag;
        disp_imm = imm; disp_q1 = q1; disp_v1 = v1; disp_q2 = q2; disp_v2 = v2;
        tick();
        disp_valid = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic commit(input logic [4:0] tag);
        rob_commit_valid = 1'b1; rob_commit_tag = tag;
        tick();
        rob_commit_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 40) begin
            tick();
            n++;
        end
        if (!mem_req) check("mem_req_timeout", 32'(mem_req), 32'd1);
    endtask

    task automatic mem_complete(input logic [31:0] rdata);
        wait_req();
        if (mem_req) begin
            mem_done = 1'b1; mem_rdata = rdata;
            tick();
            mem_done = 1'b0; mem_rdata = '0;
        end
    endtask

    task automatic load(input logic [2:0] f3, input logic [4:0] tag, input logic [31:0] v1,
                        input logic [11:0] imm, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] rdata, input logic [31:0] result);
        exp_mem(1'b0, addr, 32'd0, size);
        exp_res(tag, result, 1'b0);
        dispatch(1'b0, f3, tag, imm, 5'd0, v1, 5'd0, 32'd0);
        mem_complete(rdata);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        disp_valid = 1'b0; disp_is_store = 1'b0; disp_funct3 = '0; disp_tag = '0;
        disp_imm = '0; disp_q1 = '0; disp_q2 = '0; disp_v1 = '0; disp_v2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        rob_commit_valid = 1'b0; rob_commit_tag = '0;
        mem_done = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_full", 32'(full), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_st_ready", 32'(st_ready_valid), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_exc", 32'(res_exc), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        rst = 1'b0;
        tick();

        // Loads of each width and extension; negative offset.
        load(3'b010, 5'd1, 32'h100, 12'h004, 32'h104, 2'b10, 32'hDEADBEEF, 32'hDEADBEEF);
        load(3'b000, 5'd2, 32'h200, 12'h000, 32'h200, 2'b00, 32'h00000080, 32'hFFFFFF80);
        load(3'b100, 5'd3, 32'h200, 12'h000, 32'h200, 2'b00, 32'h00000080, 32'h00000080);
        load(3'b001, 5'd5, 32'h202, 12'h000, 32'h202, 2'b01, 32'h00008001, 32'hFFFF8001);
        load(3'b101, 5'd6, 32'h202, 12'h000, 32'h202, 2'b01, 32'h00008001, 32'h00008001);
        load(3'b010, 5'd7, 32'h100, 12'hFFC, 32'h0FC, 2'b10, 32'h12345678, 32'h12345678);

        // Store waits on data from the CDB, then on commit.
        st_exp_q.push_back(5'd4);
        exp_mem(1'b1, 32'h308, 32'h55, 2'b10);
        dispatch(1'b1, 3'b010, 5'd4, 12'h008, 5'd0, 32'h300, 5'd7, 32'd0);
        idle(3);
        check("st_pending_no_req", 32'(mem_req), 32'd0);
        cdb(5'd7, 32'h55);
        idle(4);
        check("no_req_before_commit", 32'(mem_req), 32'd0);
        commit(5'd4);
        mem_complete(32'd0);

        // Same-cycle CDB wakeup at dispatch; commit coincides with the ready pulse.
        st_exp_q.push_back(5'd8);
        exp_mem(1'b1, 32'h404, 32'h1234, 2'b01);
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'hABCD1234;
        dispatch(1'b1, 3'b001, 5'd8, 12'h004, 5'd0, 32'h400, 5'd9, 32'd0);
        cdb_valid = 1'b0;
        tick();
        commit(5'd8);
        mem_complete(32'd0);

        st_exp_q.push_back(5'd10);
        exp_mem(1'b1, 32'h503, 32'h78, 2'b00);
        dispatch(1'b1, 3'b000, 5'd10, 12'h003, 5'd0, 32'h500, 5'd0, 32'h12345678);
        tick();
        commit(5'd10);
        mem_complete(32'd0);

        // Fill to the full threshold behind a blocked head.
        for (int i = 0; i < 14; i++) begin
            exp_mem(1'b0, 32'h1000 + 32'(4 * i), 32'd0, 2'b10);
            exp_res(5'(i + 1), 32'(i * 32'h11), 1'b0);
            dispatch(1'b0, 3'b010, 5'(i + 1), 12'(4 * i), 5'd30, 32'd0, 5'd0, 32'd0);
            if (i == 12) check("not_full_at_13", 32'(full), 32'd0);
        end
        check("full_at_14", 32'(full), 32'd1);
        dispatch(1'b0, 3'b010, 5'd20, 12'h000, 5'd0, 32'h9000, 5'd0, 32'd0);
        check("full_held", 32'(full), 32'd1);
        cdb(5'd30, 32'h1000);
        mem_complete(32'd0);
        check("full_after_pop", 32'(full), 32'd0);
        for (int i = 1; i < 14; i++) mem_complete(32'(i * 32'h11));

        // Pointer wrap over 3*DEPTH back-to-back loads.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            load(3'b010, 5'((i % 28) + 1), 32'h2000, 12'(4 * i), 32'h2000 + 32'(4 * i), 2'b10,
                 32'hA5A50000 ^ 32'(i), 32'hA5A50000 ^ 32'(i));
        end

        // Global stall holds off a ready load.
        exp_mem(1'b0, 32'h3000, 32'd0, 2'b10);
        exp_res(5'd11, 32'hCAFEF00D, 1'b0);
        dispatch(1'b0, 3'b010, 5'd11, 12'h000, 5'd0, 32'h3000, 5'd0, 32'd0);
        rdy = 1'b0;
        idle(3);
        check("rdy_freeze", 32'(mem_req), 32'd0);
        rdy = 1'b1;
        mem_complete(32'hCAFEF00D);

        // Flush with a load on the bus: request held, result dropped.
        exp_mem(1'b0, 32'h600, 32'd0, 2'b10);
        dispatch(1'b0, 3'b010, 5'd12, 12'h000, 5'd0, 32'h600, 5'd0, 32'd0);
        wait_req();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle(2);
        check("drain_hold_req", 32'(mem_req), 32'd1);
        mem_complete(32'h1111);
        idle(3);
        check("drain_released", 32'(mem_req), 32'd0);

        // Flush with a committed store on the bus: the write completes.
        st_exp_q.push_back(5'd13);
        exp_mem(1'b1, 32'h700, 32'h99, 2'b10);
        dispatch(1'b1, 3'b010, 5'd13, 12'h000, 5'd0, 32'h700, 5'd0, 32'h99);
        tick();
        commit(5'd13);
        wait_req();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle(1);
        check("st_flush_req", 32'(mem_req), 32'd1);
        check("st_flush_we", 32'(mem_we), 32'd1);
        mem_complete(32'd0);
        idle(2);
        check("st_flush_done", 32'(mem_req), 32'd0);

        // Flush in IDLE discards waiting entries and a same-cycle dispatch.
        dispatch(1'b0, 3'b010, 5'd14, 12'h000, 5'd31, 32'd0, 5'd0, 32'd0);
        dispatch(1'b0, 3'b010, 5'd15, 12'h000, 5'd31, 32'd0, 5'd0, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cdb(5'd31, 32'h800);
        idle(4);
        check("flushed_no_req", 32'(mem_req), 32'd0);
        flush = 1'b1;
        dispatch(1'b0, 3'b010, 5'd16, 12'h000, 5'd0, 32'h900, 5'd0, 32'd0);
        flush = 1'b0;
        idle(4);
        check("flush_drops_dispatch", 32'(mem_req), 32'd0);
        load(3'b010, 5'd17, 32'hA00, 12'h010, 32'hA10, 2'b10, 32'h0BADF00D, 32'h0BADF00D);

`ifdef LSQ_MISALIGN_EN
        // Misaligned half load and word store never reach memory.
        exp_res(5'd18, 32'h101, 1'b1);
        dispatch(1'b0, 3'b001, 5'd18, 12'h001, 5'd0, 32'h100, 5'd0, 32'd0);
        idle(4);
        check("mis_load_no_req", 32'(mem_req), 32'd0);
        st_exp_q.push_back(5'd19);
        dispatch(1'b1, 3'b010, 5'd19, 12'h002, 5'd0, 32'h100, 5'd0, 32'h5);
        tick();
        commit(5'd19);
        idle(4);
        check("mis_store_no_req", 32'(mem_req), 32'd0);
        load(3'b010, 5'd21, 32'hB00, 12'h000, 32'hB00, 2'b10, 32'h600D, 32'h600D);
`endif

        idle(5);
        check("sb_mem_drained", 32'(mem_exp_q.size()), 32'd0);
        check("sb_res_drained", 32'(res_exp_q.size()), 32'd0);
        check("sb_st_drained", 32'(st_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsq_queue.md
Name: lsq_queue

Overview:
- Parametrised, in-order load/store queue for the out-of-order RISC-V core.
- Sits between dispatch, the ROB/CDB and the memory controller.
- Accepts load/store micro-ops from dispatch and wakes pending operands from CDB broadcasts.
- Executes strictly from the head: loads return sign/zero-extended data to the ROB; stores write memory only after the ROB commits them.
- Exception flush must not lose a committed store.

Parameters:
- DEPTH, 16, entry count; power of two, at least 4.
- TAG_W, 5, ROB tag width; tag 0 means "operand ready".
- XLEN, 32, data and address width.
- FULL_MARGIN, 2, free-slot reserve; full asserts when count >= DEPTH-FULL_MARGIN.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global stall; when 0, no state changes.
- flush  in  1  misprediction/exception flush from the ROB
- disp_valid  in  1  enqueue request
- disp_is_store  in  1  1 = store, 0 = load
- disp_funct3  in  3  RISC-V funct3: LB/LH/LW/LBU/LHU, SB/SH/SW
- disp_tag  in  TAG_W  ROB tag of the micro-op
- disp_imm  in  12  offset
- disp_q1 / disp_q2  in  TAG_W  producer tags for base / store data
- disp_v1 / disp_v2  in  XLEN  operand values
- full  out  1  dispatch back-pressure
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  XLEN  broadcast data
- st_ready_valid  out  1  one-cycle pulse: head store has address and data
- st_ready_tag  out  TAG_W  tag for st_ready_valid
- rob_commit_valid  in  1  ROB commit strobe
- rob_commit_tag  in  TAG_W  committed tag
- mem_req  out  1  memory request; held until mem_done
- mem_we  out  1  write enable
- mem_addr  out  XLEN  byte address
- mem_wdata  out  XLEN  store data, right-aligned
- mem_size  out  2  00 = byte, 01 = half, 10 = word
- mem_done  in  1  one-cycle completion
- mem_rdata  in  XLEN  load data, right-aligned, valid with mem_done
- res_valid  out  1  one-cycle load result pulse
- res_tag  out  TAG_W  tag for res_valid
- res_data  out  XLEN  extended load data
- res_exc  out  1  misaligned-access flag

Behaviour:
- Reset values:
  - Pointers 0, count 0, all entries invalid, state IDLE.
  - Outputs: full=0, mem_req=0, st_ready_valid=0, res_valid=0, res_exc=0. All data and tag outputs are 0.
- Pointers: head and tail are log2(DEPTH)+1 bits wide. Empty when head==tail; count=tail-head (mod 2^(log2+1)). Wrap-around is natural.
- Enqueue: when disp_valid and not full, write the entry at the tail and increment tail.
- Same-cycle wakeup: if cdb_valid and cdb_tag equals disp_q1 (or disp_q2), with the tag nonzero, store q=0 and v=cdb_data.
- Wakeup: every cycle, each valid entry whose nonzero q1 or q2 matches cdb_tag takes cdb_data and clears that q.
- An entry is ready when q1==0. A store additionally needs q2==0.
- Address = v1 + sign-extended imm, modulo 2^XLEN.
- FSM states: IDLE, ST_WAIT, MEM, DRAIN.
  - IDLE, head is a ready load: drive mem_req=1, mem_we=0, size from funct3; go to MEM.
  - IDLE, head is a ready store: pulse st_ready_valid for one cycle; go to ST_WAIT.
  - ST_WAIT: when rob_commit_valid and rob_commit_tag==head tag, drive mem_req=1, mem_we=1, mem_wdata=v2 masked to size; go to MEM.
  - A commit may arrive in the same cycle as the pulse; it is accepted.
  - MEM: request signals stay stable until mem_done.
  - MEM, on mem_done for a load: pulse res_valid with LB/LH sign-extended and LBU/LHU zero-extended data; pop head; go to IDLE.
  - MEM, on mem_done for a store: pop head; go to IDLE.
  - First result is 1 cycle after mem_done (registered).
- Flush: invalidate all entries and set tail=head. Same-cycle dispatch is dropped.
  - IDLE or ST_WAIT: go to IDLE; head resets to 0.
  - MEM with a committed store: the write completes; then go to IDLE.
  - MEM with a load: go to DRAIN. Hold mem_req until mem_done, discard the data and suppress res_valid; then go to IDLE.
  - CDB traffic in the flush cycle is ignored.
- Simultaneous enqueue and pop are both applied; count is unchanged.
- rdy=0 freezes all state. Held outputs stay; pulses are extended, not repeated.
- Reset mid-operation aborts any memory request immediately.

Optional Feature:
- Macro: LSQ_MISALIGN_EN.
- Defined:
  - Misaligned access is a half with addr[0]=1 or a word with addr[1:0]!=0.
  - Misaligned load: no mem_req; pulse res_valid with res_exc=1 and res_data=address; pop.
  - Misaligned store: st_ready_valid pulses as normal; on commit, no mem_req; head pops.
- Undefined: res_exc is tied to 0, and the low address bits are passed through unchanged.

Test Plan:
- Reset, then enqueue LW (q1=0, v1=0x100, imm=0x004) -> mem_req with addr 0x104, size 10. mem_done with rdata 0xDEADBEEF -> res_valid, res_data 0xDEADBEEF.
- LB whose rdata is 0x80 -> res_data 0xFFFFFF80. LBU of the same -> 0x00000080.
- SW with q2=7 pending; CDB tag 7 data 0x55 -> st_ready_valid. No mem_req before commit; commit tag -> mem_we=1, wdata 0x55.
- Fill to DEPTH-FULL_MARGIN entries -> full=1. Pop one -> full=0. Run 3*DEPTH operations -> pointers wrap with no loss.
- Load in MEM, flush -> the late mem_done produces no res_valid. A committed store in MEM plus flush -> the write still completes.
- With LSQ_MISALIGN_EN: LH at addr 0x101 -> no mem_req; res_exc=1, res_data 0x101.
